// File: rtl/float_pkg.sv
// float_pkg: shared IEEE-754 single-precision types and constants for the FP datapath
package float_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_W = 8;
  localparam int MANT_W = 23;
  localparam int QBITS = 27;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PINF = 32'h7F800000;
  typedef enum logic [3:0] {
    IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, DIVIDE, NORM, ROUND, PACK, DONE
  } state_t;
  typedef struct packed {
    logic sign;
    logic [9:0] exp;
    logic [23:0] mant;
  } fp_t;
  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic sub;
  } fcls_t;
endpackage

// File: rtl/float_unpack.sv
// float_unpack: split a single-precision word into sign/exp/mant and classify it
module float_unpack
  import float_pkg::*;
(
  input  logic [31:0] f,
  output fp_t         u,
  output fcls_t       c
);
  logic [EXP_W-1:0] ef;
  logic [MANT_W-1:0] mf;
  assign ef = f[30:MANT_W];
  assign mf = f[MANT_W-1:0];
  // subnormals take exponent 1 and no hidden bit so they share the normal scale
  assign u.sign = f[31];
  assign u.exp = (ef == '0) ? 10'd1 : {2'b00, ef};
  assign u.mant = {ef != '0, mf};
  assign c.zero = (ef == '0) && (mf == '0);
  assign c.sub = (ef == '0) && (mf != '0);
  assign c.inf = (ef == '1) && (mf == '0);
  assign c.nan = (ef == '1) && (mf != '0);
endmodule

// File: rtl/float_div.sv
// float_div: sequential single-precision divider z = a / b with round-to-nearest-even
module float_div
  import float_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] z,
  output logic        z_valid
);
  state_t state, state_nxt;
  logic [31:0] ar, br;
  fp_t ua_w, ub_w, ua, ub;
  fcls_t ca_w, cb_w, ca, cb;
  logic [4:0] cnt;
  logic [26:0] q;
  logic [24:0] r;
  logic s, sg, nan;
  logic signed [9:0] e;
  logic [22:0] mr;
  float_unpack u_a (.f(ar), .u(ua_w), .c(ca_w));
  float_unpack u_b (.f(br), .u(ub_w), .c(cb_w));
  logic qn, inf_r, zero_r, spec;
  logic [24:0] r_cur, mb25;
  logic ge;
  logic [23:0] r_nxt;
  logic signed [9:0] e_q, e1;
  logic [26:0] m1, mask;
  logic [4:0] sh;
  logic [23:0] m24;
  logic inc;
  logic [24:0] sum;
  // special-case classification, divider step, normalise shift and rounding increment
  always_comb begin
    qn = ca.nan | cb.nan | (ca.zero & cb.zero) | (ca.inf & cb.inf);
    inf_r = ca.inf | cb.zero;
    zero_r = ca.zero | cb.inf;
    spec = qn | inf_r | zero_r;
    mb25 = {1'b0, ub.mant};
    r_cur = (cnt == '0) ? {1'b0, ua.mant} : r;
    ge = r_cur >= mb25;
    r_nxt = ge ? 24'(r_cur - mb25) : r_cur[23:0];
    e_q = $signed(ua.exp) - $signed(ub.exp) + 10'(EXP_BIAS);
    e1 = q[26] ? e_q : e_q - 10'sd1;
    m1 = q[26] ? q : {q[25:0], 1'b0};
    sh = (e1 >= 10'sd1) ? 5'd0 : (e1 <= -10'sd25) ? 5'd26 : 5'(10'sd1 - e1);
    mask = (27'd1 << sh) - 27'd1;
    m24 = q[26:3];
    inc = q[2] & (q[1] | q[0] | s | m24[0]);
    sum = {1'b0, m24} + {24'd0, inc};
  end
  // state register; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready = state == IDLE;
    z_valid = state == DONE;
    case (state)
      IDLE:    state_nxt = in_valid ? UNPACK : IDLE;
      UNPACK:  state_nxt = SPECIAL;
      SPECIAL: state_nxt = spec ? PACK : ca.sub ? NORM_A : cb.sub ? NORM_B : DIVIDE;
      NORM_A:  state_nxt = ua.mant[22] ? (cb.sub ? NORM_B : DIVIDE) : NORM_A;
      NORM_B:  state_nxt = ub.mant[22] ? DIVIDE : NORM_B;
      DIVIDE:  state_nxt = (cnt == 5'(QBITS - 1)) ? NORM : DIVIDE;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = PACK;
      PACK:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // result register holds its value until the next operation packs
  always_ff @(posedge clk or negedge rst)
    if (!rst) z <= '0;
    else if (state == PACK) z <= nan ? QNAN : (e >= 10'sd255) ? {sg, PINF[30:0]} : {sg, e[7:0], mr};
  // operand capture, normalisation, restoring division and rounding datapath
  always_ff @(posedge clk) begin
    cnt <= (state == DIVIDE) ? cnt + 5'd1 : 5'd0;
    case (state)
      IDLE: if (in_valid) begin
        ar <= a;
        br <= b;
      end
      UNPACK: begin
        ua <= ua_w;
        ub <= ub_w;
        ca <= ca_w;
        cb <= cb_w;
      end
      SPECIAL: begin
        sg <= ua.sign ^ ub.sign;
        nan <= qn;
        e <= inf_r ? 10'sd255 : 10'sd0;
        mr <= '0;
      end
      NORM_A: begin
        ua.mant <= {ua.mant[22:0], 1'b0};
        ua.exp <= ua.exp - 10'd1;
      end
      NORM_B: begin
        ub.mant <= {ub.mant[22:0], 1'b0};
        ub.exp <= ub.exp - 10'd1;
      end
      DIVIDE: begin
        q <= {q[25:0], ge};
        r <= {r_nxt, 1'b0};
      end
      NORM: begin
        q <= m1 >> sh;
        s <= (r != '0) | ((m1 & mask) != '0);
        e <= (e1 < 10'sd1) ? 10'sd0 : e1;
      end
      ROUND: begin
        mr <= sum[24] ? sum[23:1] : sum[22:0];
        e <= sum[24] ? e + 10'sd1 : (e == 10'sd0 && sum[23]) ? 10'sd1 : e;
      end
      default: ;
    endcase
  end
endmodule
